// File: rtl/tlc_stream_decoder.sv
// Decodes a TLC-style SCLK/LAT/SIN serial stream into commands and tracks the
// grey-scale word position inside the current LED frame.
module tlc_stream_decoder #(
  parameter int NB_LEDS_PER_GROUP = 16,
  parameter int SHIFT_WIDTH       = 48
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 SCLK,
  input  logic                                 LAT,
  input  logic                                 SIN,
  input  logic                                 clear_err,
  output logic                                 word_valid,
  output logic [SHIFT_WIDTH-1:0]               word_data,
  output logic [2:0]                           word_cmd,
  output logic [$clog2(NB_LEDS_PER_GROUP)-1:0] led_index,
  output logic                                 frame_valid,
  output logic                                 err_unknown_cmd,
  output logic                                 err_overflow
);

  localparam int              IDX_W   = $clog2(NB_LEDS_PER_GROUP);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NB_LEDS_PER_GROUP - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LAT_HIGH = 2'd1,
    S_EMIT     = 2'd2
  } state_t;

  logic [2:0]             r_sclk_sync;
  logic [2:0]             r_lat_sync;
  logic [2:0]             r_sin_sync;
  logic [SHIFT_WIDTH-1:0] r_shift;
  logic [4:0]             r_lat_cnt;
  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_wrapped;
  logic                   r_word_valid;
  logic                   r_frame_valid;
  logic [SHIFT_WIDTH-1:0] r_word_data;
  logic [2:0]             r_word_cmd;
  logic [IDX_W-1:0]       r_led_index;
  logic                   r_err_unk;
  logic                   r_err_ovf;

  logic                   w_sclk_rise;
  logic                   w_lat_rise;
  logic                   w_lat_fall;
  logic [SHIFT_WIDTH-1:0] w_shift_next;
  logic [4:0]             w_cnt_applied;
  logic [4:0]             w_lat_cnt_next;
  state_t                 w_state_next;
  logic                   w_emit;
  logic [2:0]             w_cmd;
  logic [IDX_W-1:0]       w_idx_next;
  logic                   w_wrapped_next;
  logic                   w_ovf_set;
  logic                   w_unk_set;

  function automatic logic [2:0] decode_cmd(input logic [4:0] cnt);
    case (cnt)
      5'd1:    decode_cmd = 3'd0;
      5'd3:    decode_cmd = 3'd1;
      5'd5:    decode_cmd = 3'd2;
      5'd7:    decode_cmd = 3'd3;
      5'd11:   decode_cmd = 3'd4;
      5'd13:   decode_cmd = 3'd5;
      5'd15:   decode_cmd = 3'd6;
      default: decode_cmd = 3'd7;
    endcase
  endfunction

  // Index 1 of each chain is the synchronized level, index 2 the previous one.
  assign w_sclk_rise  = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_lat_rise   = r_lat_sync[1] & ~r_lat_sync[2];
  assign w_lat_fall   = ~r_lat_sync[1] & r_lat_sync[2];
  assign w_shift_next = w_sclk_rise ? {r_shift[SHIFT_WIDTH-2:0], r_sin_sync[2]} : r_shift;

  // A SCLK edge arriving with the LAT fall still counts toward the decoded length.
  assign w_cnt_applied = (w_sclk_rise && (r_lat_cnt != 5'd31)) ? (r_lat_cnt + 5'd1) : r_lat_cnt;
  assign w_cmd         = decode_cmd(w_cnt_applied);

  always_comb begin
    w_state_next   = r_state;
    w_lat_cnt_next = r_lat_cnt;
    w_emit         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_lat_rise) begin
          w_state_next   = S_LAT_HIGH;
          w_lat_cnt_next = 5'd0;
        end else begin
          w_state_next   = S_IDLE;
        end
      end
      S_LAT_HIGH: begin
        w_lat_cnt_next = w_cnt_applied;
        if (w_lat_fall) begin
          w_state_next = S_EMIT;
          w_emit       = (w_cnt_applied != 5'd0);
        end else begin
          w_state_next = S_LAT_HIGH;
        end
      end
      S_EMIT:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // r_wrapped marks that every slot of the frame has been consumed.
  always_comb begin
    w_idx_next     = r_idx;
    w_wrapped_next = r_wrapped;
    w_ovf_set      = 1'b0;
    w_unk_set      = 1'b0;
    if (w_emit) begin
      case (w_cmd)
        3'd0: begin
          w_ovf_set = r_wrapped;
          if (r_idx == IDX_MAX) begin
            w_idx_next     = '0;
            w_wrapped_next = 1'b1;
          end else begin
            w_idx_next     = r_idx + IDX_W'(1);
          end
        end
        3'd1, 3'd3: begin
          w_idx_next     = '0;
          w_wrapped_next = 1'b0;
        end
        3'd7:    w_unk_set = 1'b1;
        default: w_unk_set = 1'b0;
      endcase
    end else begin
      w_unk_set = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sync   <= 3'd0;
      r_lat_sync    <= 3'd0;
      r_sin_sync    <= 3'd0;
      r_shift       <= '0;
      r_lat_cnt     <= 5'd0;
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_wrapped     <= 1'b0;
      r_word_valid  <= 1'b0;
      r_frame_valid <= 1'b0;
      r_word_data   <= '0;
      r_word_cmd    <= 3'd0;
      r_led_index   <= '0;
      r_err_unk     <= 1'b0;
      r_err_ovf     <= 1'b0;
    end else begin
      r_sclk_sync   <= {r_sclk_sync[1:0], SCLK};
      r_lat_sync    <= {r_lat_sync[1:0], LAT};
      r_sin_sync    <= {r_sin_sync[1:0], SIN};
      r_shift       <= w_shift_next;
      r_lat_cnt     <= w_lat_cnt_next;
      r_state       <= w_state_next;
      r_idx         <= w_idx_next;
      r_wrapped     <= w_wrapped_next;
      r_word_valid  <= w_emit;
      r_frame_valid <= w_emit && (w_cmd == 3'd1);
      if (w_emit) begin
        r_word_data <= w_shift_next;
        r_word_cmd  <= w_cmd;
        r_led_index <= r_idx;
      end else begin
        r_word_data <= r_word_data;
        r_word_cmd  <= r_word_cmd;
        r_led_index <= r_led_index;
      end
      // A new error wins over a simultaneous clear.
      r_err_unk     <= (r_err_unk & ~clear_err) | w_unk_set;
      r_err_ovf     <= (r_err_ovf & ~clear_err) | w_ovf_set;
    end
  end

  assign word_valid      = r_word_valid;
  assign frame_valid     = r_frame_valid;
  assign word_data       = r_word_data;
  assign word_cmd        = r_word_cmd;
  assign led_index       = r_led_index;
  assign err_unknown_cmd = r_err_unk;
  assign err_overflow    = r_err_ovf;

endmodule

// File: doc/tlc_stream_decoder.md
TLC_STREAM_DECODER -- requirements
Module: tlc_stream_decoder

Interface
REQ-001 Parameter NB_LEDS_PER_GROUP, default 16, meaning the number of WRTGS words per LATGS frame.
REQ-002 Parameter SHIFT_WIDTH, default 48, meaning the serial word length in bits.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 SCLK  input  1  serial clock from the LED band controller or HPS override; asynchronous, sampled in clk.
REQ-006 LAT  input  1  latch/command strobe; asynchronous, sampled in clk.
REQ-007 SIN  input  1  serial data, MSB first; asynchronous, sampled in clk.
REQ-008 clear_err  input  1  synchronous clear of both sticky error flags.
REQ-009 word_valid  output  1  one-cycle pulse: a command has been decoded.
REQ-010 word_data  output  SHIFT_WIDTH  shift register contents at the LAT falling edge.
REQ-011 word_cmd  output  3  decoded command: 0 WRTGS, 1 LATGS, 2 WRTFC, 3 LINERESET, 4 READFC, 5 TMGRST, 6 FCWRTEN, 7 unknown.
REQ-012 led_index  output  $clog2(NB_LEDS_PER_GROUP)  word position within the frame for WRTGS/LATGS words.
REQ-013 frame_valid  output  1  one-cycle pulse, coincident with word_valid, on LATGS.
REQ-014 err_unknown_cmd  output  1  sticky flag: unknown LAT length seen.
REQ-015 err_overflow  output  1  sticky flag: more than NB_LEDS_PER_GROUP GS words in one frame.

Function
REQ-016 SCLK, LAT and SIN SHALL each pass through a 2-flop synchronizer; a third register per signal provides edge detection.
REQ-017 On each detected SCLK rise, the block SHALL shift the synchronized SIN into bit 0 of the shift register and shift the existing contents toward the MSB; shifting occurs regardless of LAT.
REQ-018 State machine: IDLE -> LAT_HIGH on a synchronized LAT rise, with lat_cnt cleared to 0.
REQ-019 State machine: in LAT_HIGH, each SCLK rise SHALL increment lat_cnt (5 bits, saturating at 31).
REQ-020 State machine: LAT_HIGH -> EMIT on a synchronized LAT fall; EMIT -> IDLE after exactly 1 cycle.
REQ-021 If an SCLK rise and a LAT fall are detected in the same cycle, the SCLK edge SHALL be applied to both the shift register and lat_cnt before decode.
REQ-022 Decode map from lat_cnt to word_cmd: 1 -> 0, 3 -> 1, 5 -> 2, 7 -> 3, 11 -> 4, 13 -> 5, 15 -> 6, any other nonzero value -> 7.
REQ-023 A lat_cnt of 0 at the LAT fall SHALL produce no output and no error.
REQ-024 In EMIT, word_valid SHALL be 1 for one cycle, with word_data, word_cmd and led_index registered and held stable until the next word_valid.
REQ-025 Latency: word_valid SHALL assert on the 3rd clk rising edge after LAT falls at the input, provided LAT meets setup time.
REQ-026 WRTGS SHALL output the current led_index, then increment it modulo NB_LEDS_PER_GROUP.
REQ-027 A WRTGS with led_index == NB_LEDS_PER_GROUP-1 already consumed (17th WRTGS without an intervening LATGS) SHALL set err_overflow; the index wraps to 0.
REQ-028 LATGS SHALL output the current led_index, pulse frame_valid, and reset the index to 0.
REQ-029 LINERESET SHALL reset the index to 0.
REQ-030 All other commands SHALL leave the index unchanged.
REQ-031 cmd 7 SHALL set err_unknown_cmd.
REQ-032 If clear_err and a new error occur in the same cycle, the error flag SHALL end up set.
REQ-033 Minimum SCLK high and low time is 2 clk cycles; faster SCLK is out of scope.

Reset
REQ-034 While rst=0, all synchronizer and edge registers, the shift register, lat_cnt, led_index, word_data, word_cmd and both error flags SHALL be 0, and state SHALL be IDLE.
REQ-035 word_valid and frame_valid SHALL be 0 during reset.
REQ-036 Reset asserted mid-command SHALL discard the partial word with no output.
REQ-037 If LAT is high at reset release, it SHALL be treated as a fresh LAT rise with lat_cnt starting at 0.

Verification
REQ-038 Shift 48'h5c0201008048, then LAT high for 5 SCLK rises -> one word_valid, word_cmd=2, word_data=48'h5c0201008048 (the last 5 bits shifted while LAT is high are included).
REQ-039 16 WRTGS words with random data, then one LATGS word -> led_index 0..15 in order; the LATGS word has index 0 with frame_valid=1; err_overflow stays 0.
REQ-040 17 WRTGS words with no LATGS -> 17th word has led_index=0 and err_overflow=1; clear_err -> err_overflow=0 next cycle.
REQ-041 LAT high for 4 SCLK rises -> word_cmd=7, err_unknown_cmd=1; LAT pulse with 0 SCLK rises -> no word_valid.
REQ-042 rst=0 asserted after 20 SCLK rises within a word -> all outputs 0; after release, a full WRTGS word -> led_index=0 and correct data.
REQ-043 Loopback with led_band_controller at SCLK = clk/4 -> decoded WRTGS data for mux row 0 matches the colour memory contents for the LEDs mapped by the multiplexing table.
